// File: rtl/cs_microsequencer.sv
// Next-address engine for the microprogrammed control unit: CSAR, condition decode, call/return stack, ACK wait, sticky error.
// Optional ACK watchdog enabled by defining CS_MICROSEQUENCER_ACK_TIMEOUT_EN.
//
// state | meaning
// RUN   | evaluate COND each cycle unless a memory request is unacknowledged
// WAIT  | memory request outstanding; CSAR holds until ACK
// ERR   | stack fault or ACK timeout; frozen until reset
module cs_microsequencer #(
    parameter int ADDR_WIDTH     = 11,
    parameter int STACK_DEPTH    = 4,
    parameter int RESET_ADDR     = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               CS_MICROSEQUENCER_CLOCK_50,
    input  logic                               CS_MICROSEQUENCER_RESET_InHigh,
    input  logic [3:0]                         CS_MICROSEQUENCER_COND_InBUS,
    input  logic [ADDR_WIDTH-1:0]              CS_MICROSEQUENCER_JUMP_ADDR_InBUS,
    input  logic                               CS_MICROSEQUENCER_RD,
    input  logic                               CS_MICROSEQUENCER_WR,
    input  logic                               CS_MICROSEQUENCER_ACK,
    input  logic [31:0]                        CS_MICROSEQUENCER_IR_InBUS,
    input  logic [3:0]                         CS_MICROSEQUENCER_FLAGS_InBUS,
    output logic [ADDR_WIDTH-1:0]              CS_MICROSEQUENCER_ADDR_OutBUS,
    output logic                               CS_MICROSEQUENCER_STALL,
    output logic [$clog2(STACK_DEPTH):0]       CS_MICROSEQUENCER_DEPTH_OutBUS,
    output logic                               CS_MICROSEQUENCER_ERROR
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    if (ADDR_WIDTH < 11 || STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0
        || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("cs_microsequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    logic                  clk, rst, ack, req;
    logic [3:0]            cond;
    logic [31:0]           ir;
    logic                  n, z, v, c;
    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] csar, csar_next, csar_inc, decode_addr;
    logic [DW-1:0]         depth, depth_next;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic                  push, evaluate, taken;
    logic                  unused_ir;

    assign clk          = CS_MICROSEQUENCER_CLOCK_50;
    assign rst          = CS_MICROSEQUENCER_RESET_InHigh;
    assign ack          = CS_MICROSEQUENCER_ACK;
    assign req          = CS_MICROSEQUENCER_RD | CS_MICROSEQUENCER_WR;
    assign cond         = CS_MICROSEQUENCER_COND_InBUS;
    assign ir           = CS_MICROSEQUENCER_IR_InBUS;
    assign {n, z, v, c} = CS_MICROSEQUENCER_FLAGS_InBUS;
    assign csar_inc     = csar + ADDR_WIDTH'(1);
    assign decode_addr  = ADDR_WIDTH'({1'b1, ir[31:30], ir[24:19], 2'b00});
    assign unused_ir    = ^{ir[29:25], ir[18:14], ir[12:0]};

`ifdef CS_MICROSEQUENCER_ACK_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
    logic [TW-1:0] wait_cnt;

    // Counter sits at zero outside WAIT, so it is already clear on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state != WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + TW'(1);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            csar  <= ADDR_WIDTH'(RESET_ADDR);
            depth <= '0;
        end else begin
            state <= state_next;
            csar  <= csar_next;
            depth <= depth_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stack_mem[depth[PW-1:0]] <= csar_inc;
    end

    always_comb begin
        taken = 1'b0;
        case (cond)
            4'd1:    taken = n;
            4'd2:    taken = z;
            4'd3:    taken = v;
            4'd4:    taken = c;
            4'd5:    taken = ir[13];
            4'd6:    taken = 1'b1;
            4'd10:   taken = n ^ v;
            4'd11:   taken = c | z;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        csar_next  = csar;
        depth_next = depth;
        push       = 1'b0;
        evaluate   = 1'b0;
        case (state)
            RUN: begin
                if (req && !ack)
                    state_next = WAIT;
                else
                    evaluate = 1'b1;
            end
            WAIT: begin
                if (ack) begin
                    evaluate   = 1'b1;
                    state_next = RUN;
                end
`ifdef CS_MICROSEQUENCER_ACK_TIMEOUT_EN
                else if (wait_cnt == TW'(TIMEOUT_CYCLES))
                    state_next = ERR;
`endif
            end
            default: state_next = ERR;
        endcase

        if (evaluate) begin
            case (cond)
                4'd7: csar_next = decode_addr;
                4'd8: begin
                    if (depth == DW'(STACK_DEPTH)) begin
                        state_next = ERR;
                    end else begin
                        push       = 1'b1;
                        depth_next = depth + DW'(1);
                        csar_next  = CS_MICROSEQUENCER_JUMP_ADDR_InBUS;
                    end
                end
                4'd9: begin
                    if (depth == '0) begin
                        state_next = ERR;
                    end else begin
                        depth_next = depth - DW'(1);
                        csar_next  = stack_mem[PW'(depth - DW'(1))];
                    end
                end
                default: csar_next = taken ? CS_MICROSEQUENCER_JUMP_ADDR_InBUS : csar_inc;
            endcase
        end
    end

    always_comb begin
        CS_MICROSEQUENCER_STALL = 1'b0;
        CS_MICROSEQUENCER_ERROR = 1'b0;
        case (state)
            RUN:  CS_MICROSEQUENCER_STALL = req && !ack;
            WAIT: CS_MICROSEQUENCER_STALL = !ack;
            default: begin
                CS_MICROSEQUENCER_STALL = 1'b1;
                CS_MICROSEQUENCER_ERROR = 1'b1;
            end
        endcase
    end

    assign CS_MICROSEQUENCER_ADDR_OutBUS  = csar;
    assign CS_MICROSEQUENCER_DEPTH_OutBUS = depth;
endmodule

// File: tb/tb_cs_microsequencer.sv
// Self-checking bench for cs_microsequencer: directed scenarios plus randomized traffic against a queue-based model.
module tb_cs_microsequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cond = '0;
    logic [10:0] jump = '0;
    logic        rd = 1'b0, wr = 1'b0, ack = 1'b1;
    logic [31:0] ir = '0;
    logic [3:0]  flags = '0;
    logic [10:0] addr;
    logic        stall, error;
    logic [2:0]  depth;

    int tests_run = 0;
    int tests_failed = 0;

    int m_addr;
    int m_stack[$];
    bit m_err, m_wait;

    cs_microsequencer dut (
        .CS_MICROSEQUENCER_CLOCK_50       (clk),
        .CS_MICROSEQUENCER_RESET_InHigh   (rst),
        .CS_MICROSEQUENCER_COND_InBUS     (cond),
        .CS_MICROSEQUENCER_JUMP_ADDR_InBUS(jump),
        .CS_MICROSEQUENCER_RD             (rd),
        .CS_MICROSEQUENCER_WR             (wr),
        .CS_MICROSEQUENCER_ACK            (ack),
        .CS_MICROSEQUENCER_IR_InBUS       (ir),
        .CS_MICROSEQUENCER_FLAGS_InBUS    (flags),
        .CS_MICROSEQUENCER_ADDR_OutBUS    (addr),
        .CS_MICROSEQUENCER_STALL          (stall),
        .CS_MICROSEQUENCER_DEPTH_OutBUS   (depth),
        .CS_MICROSEQUENCER_ERROR          (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int c, input int j, input bit r, input bit w, input bit a,
                         input logic [31:0] i, input logic [3:0] f);
        cond = 4'(c); jump = 11'(j); rd = r; wr = w; ack = a; ir = i; flags = f;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(0, 0, 0, 0, 1, 0, 0);
        tick();
        rst = 1'b0;
        m_addr = 0; m_stack.delete(); m_err = 0; m_wait = 0;
    endtask

    function automatic bit model_stall();
        return m_err || (!ack && (m_wait || rd || wr));
    endfunction

    // Abstract sequencer: branch rules from the condition table, stack as a queue.
    function automatic void model_step();
        bit t;
        int a;
        if (m_err) return;
        if (!ack && (m_wait || rd || wr)) begin
            m_wait = 1;
            return;
        end
        m_wait = 0;
        a = int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4 + 1024;
        case (int'(cond))
            1: t = flags[3];
            2: t = flags[2];
            3: t = flags[1];
            4: t = flags[0];
            5: t = ir[13];
            6: t = 1;
            10: t = flags[3] ^ flags[1];
            11: t = flags[0] | flags[2];
            default: t = 0;
        endcase
        if (cond == 7) m_addr = a;
        else if (cond == 8) begin
            if (m_stack.size() == 4) m_err = 1;
            else begin
                m_stack.push_back((m_addr + 1) % 2048);
                m_addr = int'(jump);
            end
        end else if (cond == 9) begin
            if (m_stack.size() == 0) m_err = 1;
            else m_addr = m_stack.pop_back();
        end else m_addr = t ? int'(jump) : (m_addr + 1) % 2048;
    endfunction

    task automatic test_reset();
        do_reset();
        tests_run++; if (addr !== 11'h000) begin tests_failed++; $display("FAIL reset_addr: got %h want 000", addr); end
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b want 0", error); end
        tests_run++; if (depth !== 3'd0) begin tests_failed++; $display("FAIL reset_depth: got %0d want 0", depth); end
        for (int k = 1; k <= 3; k++) begin
            apply(0, 11'h3FF, 0, 0, 1, 0, 0);
            tick();
            tests_run++; if (addr !== 11'(k) || stall !== 1'b0) begin tests_failed++; $display("FAIL seq_incr: got addr=%h stall=%b want addr=%h stall=0", addr, stall, 11'(k)); end
        end
    endtask

    task automatic test_branch();
        do_reset();
        apply(2, 11'h150, 0, 0, 1, 0, 4'b0100);
        tick();
        tests_run++; if (addr !== 11'h150) begin tests_failed++; $display("FAIL branch_z_taken: got %h want 150", addr); end
        apply(2, 11'h2AA, 0, 0, 1, 0, 4'b1011);
        tick();
        tests_run++; if (addr !== 11'h151) begin tests_failed++; $display("FAIL branch_z_not_taken: got %h want 151", addr); end
        apply(10, 11'h0C0, 0, 0, 1, 0, 4'b1000);
        tick();
        tests_run++; if (addr !== 11'h0C0) begin tests_failed++; $display("FAIL branch_lt: got %h want 0c0", addr); end
        apply(13, 11'h444, 0, 0, 1, 0, 4'b1111);
        tick();
        tests_run++; if (addr !== 11'h0C1) begin tests_failed++; $display("FAIL reserved_cond: got %h want 0c1", addr); end
        // {1, 2'b10, 6'b111000, 2'b00} = 1024 + 512 + 224
        apply(7, 11'h001, 0, 0, 1, 32'h8000_0000 | (32'h38 << 19), 0);
        tick();
        tests_run++; if (addr !== 11'h6E0) begin tests_failed++; $display("FAIL decode: got %h want 6e0", addr); end
        apply(6, 11'h7FF, 0, 0, 1, 0, 0);
        tick();
        apply(0, 0, 0, 0, 1, 0, 0);
        tick();
        tests_run++; if (addr !== 11'h000 || error !== 1'b0) begin tests_failed++; $display("FAIL wrap: got addr=%h err=%b want 000/0", addr, error); end
    endtask

    task automatic test_call_return();
        logic [10:0] want_a [4] = '{11'h200, 11'h300, 11'h206, 11'h011};
        logic [2:0]  want_d [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
        int          cs [4] = '{8, 8, 9, 9};
        int          js [4] = '{11'h200, 11'h300, 0, 0};
        do_reset();
        apply(6, 11'h010, 0, 0, 1, 0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                apply(6, 11'h205, 0, 0, 1, 0, 0);
                tick();
            end
            apply(cs[k], js[k], 0, 0, 1, 0, 0);
            tick();
            tests_run++; if (addr !== want_a[k] || depth !== want_d[k]) begin tests_failed++; $display("FAIL call_ret_%0d: got addr=%h depth=%0d want addr=%h depth=%0d", k, addr, depth, want_a[k], want_d[k]); end
        end
    endtask

    task automatic test_wait();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            apply(6, 11'h040, 1, 0, 0, 0, 0);
            tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL wait_stall_%0d: got %b want 1", k, stall); end
            tick();
            tests_run++; if (addr !== 11'h000) begin tests_failed++; $display("FAIL wait_hold_%0d: got %h want 000", k, addr); end
        end
        apply(6, 11'h040, 1, 0, 1, 0, 0);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL wait_ack_stall: got %b want 0", stall); end
        tick();
        tests_run++; if (addr !== 11'h040) begin tests_failed++; $display("FAIL wait_release: got %h want 040", addr); end
        // Flags seen during WAIT must not affect the branch decision.
        apply(2, 11'h123, 0, 1, 0, 0, 4'b0100);
        tick();
        apply(2, 11'h123, 0, 1, 0, 0, 4'b0100);
        tick();
        apply(2, 11'h123, 0, 1, 1, 0, 4'b0000);
        tick();
        tests_run++; if (addr !== 11'h041) begin tests_failed++; $display("FAIL wait_flag_sample: got %h want 041", addr); end
        apply(6, 11'h0AA, 0, 1, 1, 0, 0);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL ack_early_stall: got %b want 0", stall); end
        tick();
        tests_run++; if (addr !== 11'h0AA) begin tests_failed++; $display("FAIL ack_early: got %h want 0aa", addr); end
    endtask

    task automatic test_errors();
        do_reset();
        apply(6, 11'h033, 0, 0, 1, 0, 0);
        tick();
        apply(9, 0, 0, 0, 1, 0, 0);
        tick();
        tests_run++; if (error !== 1'b1 || stall !== 1'b1 || addr !== 11'h033) begin tests_failed++; $display("FAIL underflow: got err=%b stall=%b addr=%h want 1/1/033", error, stall, addr); end
        apply(6, 11'h077, 0, 0, 1, 0, 0);
        tick();
        tests_run++; if (error !== 1'b1 || addr !== 11'h033) begin tests_failed++; $display("FAIL err_sticky: got err=%b addr=%h want 1/033", error, addr); end
        rst = 1'b1;
        #1;
        tests_run++; if (error !== 1'b0 || addr !== 11'h000 || stall !== 1'b0) begin tests_failed++; $display("FAIL err_async_reset: got err=%b addr=%h stall=%b want 0/000/0", error, addr, stall); end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            apply(8, 11'h100 + k, 0, 0, 1, 0, 0);
            tick();
        end
        apply(8, 11'h500, 0, 0, 1, 0, 0);
        tick();
        tests_run++; if (error !== 1'b1 || depth !== 3'd4 || addr !== 11'h103) begin tests_failed++; $display("FAIL overflow: got err=%b depth=%0d addr=%h want 1/4/103", error, depth, addr); end
        do_reset();
        apply(8, 11'h200, 0, 0, 1, 0, 0);
        tick();
        apply(6, 11'h300, 1, 0, 0, 0, 0);
        tick();
        apply(8, 11'h300, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        tests_run++; if (depth !== 3'd0 || addr !== 11'h000 || stall !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_wait: got depth=%0d addr=%h stall=%b want 0/000/0", depth, addr, stall); end
    endtask

    task automatic test_random();
        bit exp_stall;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            apply($urandom_range(15), $urandom_range(2047), $urandom_range(4) == 0,
                  $urandom_range(9) == 0, $urandom_range(9) < 7, $urandom, 4'($urandom_range(15)));
            exp_stall = model_stall();
            tests_run++; if (stall !== exp_stall) begin tests_failed++; $display("FAIL rand_stall[%0d]: got %b want %b", k, stall, exp_stall); end
            tick();
            model_step();
            tests_run++;
            if (addr !== 11'(m_addr) || depth !== 3'(m_stack.size()) || error !== m_err) begin
                tests_failed++;
                $display("FAIL rand_state[%0d]: got addr=%h depth=%0d err=%b want addr=%h depth=%0d err=%b",
                         k, addr, depth, error, 11'(m_addr), m_stack.size(), m_err);
            end
            if (m_err || error) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_return();
        test_wait();
        test_errors();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
